dmni_brlite_mon_writer: RTL

- Downstream consumer of BrLite monitor packets (brlite_mon_t) delivered by the BrLite router to the DMNI.
- Buffers each packet, then writes its payload into the software-owned monitoring table of its service (QoS or PWR) in local memory.
- Table base pointers are programmed through the DMNI_BR_MON_PTR_QOS/PWR MMRs. DMNI_BR_MON_CLEAR disables all tables and flushes the buffer.

---
 rtl/dmni_brlite_mon_writer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dmni_brlite_mon_writer.sv
// BrLite monitor packet writer: buffers monitor packets from the router and
// stores each payload into the per-service monitoring table in local memory.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a buffered packet; pops the FIFO head
// S_CALC  | validates the entry and computes the table slot address
// S_WRITE | memory write request held until granted
module dmni_brlite_mon_writer #(
  parameter  int MESH_X     = 4,
  parameter  int MESH_Y     = 4,
  parameter  int MON_NSVC   = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int SVC_W      = (MON_NSVC > 1) ? $clog2(MON_NSVC) : 1,
  localparam int MON_W      = 64 + SVC_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mon_valid_i,
  output logic             mon_ready_o,
  input  logic [MON_W-1:0] mon_i,
  input  logic             ptr_we_i,
  input  logic [SVC_W-1:0] ptr_sel_i,
  input  logic [31:0]      ptr_data_i,
  input  logic             clear_i,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic             busy_o,
  output logic [15:0]      drop_cnt_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 48 + SVC_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // The sequence number is not written to the table, so it is not buffered.
  logic             unused_seq;
  logic [ENT_W-1:0] mon_fields;

  assign unused_seq = ^mon_i[SVC_W+16 +: 16];
  assign mon_fields = {mon_i[SVC_W+32 +: 32], mon_i[SVC_W +: 16], mon_i[SVC_W-1:0]};

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, fifo_cnt;
  logic             fifo_full, fifo_empty, push, pop;

  assign fifo_cnt    = wr_ptr - rd_ptr;
  assign fifo_full   = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign mon_ready_o = !fifo_full;
  assign push        = mon_valid_i && !fifo_full && !clear_i;
  assign pop         = (state_q == S_IDLE) && !fifo_empty && !clear_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= mon_fields;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic [31:0] ptr_q [MON_NSVC];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MON_NSVC; i++) ptr_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < MON_NSVC; i++) ptr_q[i] <= '0;
    end else if (ptr_we_i && (32'(ptr_sel_i) < MON_NSVC)) begin
      ptr_q[ptr_sel_i] <= ptr_data_i;
    end
  end

  logic [ENT_W-1:0] entry_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else if (pop) begin
      entry_q <= fifo_mem[rd_ptr[AW-1:0]];
    end
  end

  logic [SVC_W-1:0] ent_svc;
  logic [7:0]       prod_y, prod_x;
  logic [31:0]      ent_payload, sel_ptr, calc_addr;
  logic [15:0]      idx;
  logic             svc_ok, calc_drop;

  assign ent_svc     = entry_q[SVC_W-1:0];
  assign prod_x      = entry_q[SVC_W +: 8];
  assign prod_y      = entry_q[SVC_W+8 +: 8];
  assign ent_payload = entry_q[SVC_W+16 +: 32];

  always_comb begin
    svc_ok    = (32'(ent_svc) < MON_NSVC);
    sel_ptr   = svc_ok ? ptr_q[ent_svc] : 32'd0;
    idx       = 16'(32'(prod_y) * MESH_X + 32'(prod_x));
    calc_addr = sel_ptr + {14'd0, idx, 2'b00};
    calc_drop = !svc_ok || (sel_ptr == 32'd0) ||
                (32'(prod_y) >= MESH_Y) || (32'(prod_x) >= MESH_X);
  end

  logic drop_inc, load_req;

  always_comb begin
    state_d  = state_q;
    drop_inc = 1'b0;
    load_req = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_CALC;
      end
      S_CALC: begin
        // A clear abandons the entry silently; it is not counted as a drop.
        if (clear_i) begin
          state_d = S_IDLE;
        end else if (calc_drop) begin
          drop_inc = 1'b1;
          state_d  = S_IDLE;
        end else begin
          load_req = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_gnt_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else if (load_req) begin
      mem_addr_o <= calc_addr;
      mem_data_o <= ent_payload;
    end
  end

  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (clear_i) begin
      drop_cnt_q <= '0;
    end else if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign mem_req_o  = (state_q == S_WRITE);
  assign busy_o     = (state_q != S_IDLE) || !fifo_empty;
  assign drop_cnt_o = drop_cnt_q;

endmodule
